// File: rtl/capture_readout_ctrl.sv
// Capture FIFO readout sequencer: pops SampleCount words and streams them LSB-byte-first
// on a valid/ready byte link. Define READOUT_HEADER_EN to prefix a 3-byte header (A5, count).
module capture_readout_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 12
) (
    input  logic              CLK,
    input  logic              locked,
    input  logic              ENOUT,
    input  logic [CNT_W-1:0]  SampleCount,
    input  logic              rdempty,
    output logic              rdreq,
    input  logic [DATA_W-1:0] q,
    output logic [7:0]        TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              FinishRD,
    output logic              Underrun,
    output logic              Busy,
    output logic [2:0]        state
);

    localparam int NBYTES = DATA_W / 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

    logic [2:0]        r_state;
    logic              r_enout_d;
    logic [CNT_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_shift;
    logic [1:0]        r_idx;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_rdreq;
    logic              r_finish;
    logic              r_underrun;
    logic              r_busy;

    logic [2:0]        w_state_next;
    logic [CNT_W-1:0]  w_remaining_next;
    logic [DATA_W-1:0] w_shift_next;
    logic [1:0]        w_idx_next;
    logic [7:0]        w_tx_data_next;
    logic              w_tx_valid_next;
    logic              w_rdreq_next;
    logic              w_finish_next;
    logic              w_underrun_next;
    logic              w_enout_rise;
    logic              w_handshake;
    logic [DATA_W-1:0] w_shifted;

`ifdef READOUT_HEADER_EN
    logic [15:0]       w_count16;
    assign w_count16 = 16'(r_remaining);
`endif

    assign w_enout_rise = ENOUT && !r_enout_d;
    assign w_handshake  = r_tx_valid && TxReady;
    assign w_shifted    = r_shift >> 8;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no latch is inferred.
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_shift_next     = r_shift;
        w_idx_next       = r_idx;
        w_tx_data_next   = r_tx_data;
        w_tx_valid_next  = r_tx_valid;
        w_rdreq_next     = 1'b0;
        w_finish_next    = r_finish;
        w_underrun_next  = r_underrun;

        if (r_state != S_IDLE && !ENOUT) begin
            w_state_next    = S_IDLE;
            w_tx_valid_next = 1'b0;
            w_finish_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enout_rise) begin
                        w_remaining_next = SampleCount;
                        w_underrun_next  = 1'b0;
`ifdef READOUT_HEADER_EN
                        w_state_next     = S_HDR;
                        w_tx_data_next   = 8'hA5;
                        w_tx_valid_next  = 1'b1;
                        w_idx_next       = 2'd0;
`else
                        if (SampleCount == '0) begin
                            w_state_next  = S_DONE;
                            w_finish_next = 1'b1;
                        end else begin
                            w_state_next = S_REQ;
                            w_rdreq_next = !rdempty;
                        end
`endif
                    end
                end
                S_HDR: begin
`ifdef READOUT_HEADER_EN
                    if (w_handshake) begin
                        case (r_idx)
                            2'd0: begin
                                w_tx_data_next = w_count16[7:0];
                                w_idx_next     = 2'd1;
                            end
                            2'd1: begin
                                w_tx_data_next = w_count16[15:8];
                                w_idx_next     = 2'd2;
                            end
                            default: begin
                                w_tx_valid_next = 1'b0;
                                if (r_remaining == '0) begin
                                    w_state_next  = S_DONE;
                                    w_finish_next = 1'b1;
                                end else begin
                                    w_state_next = S_REQ;
                                    w_rdreq_next = !rdempty;
                                end
                            end
                        endcase
                    end
`else
                    w_state_next = S_IDLE;
`endif
                end
                // rdreq is registered, so the REQ decision uses the empty flag sampled on
                // entry; only writes can change it meanwhile, so no read of an empty FIFO.
                S_REQ: begin
                    if (!r_rdreq) begin
                        w_underrun_next = 1'b1;
                        w_finish_next   = 1'b1;
                        w_state_next    = S_DONE;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_shift_next    = q;
                    w_tx_data_next  = q[7:0];
                    w_tx_valid_next = 1'b1;
                    w_idx_next      = 2'd0;
                    w_state_next    = S_SEND;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        if (r_idx == LAST_BYTE) begin
                            w_tx_valid_next = 1'b0;
                            if (r_remaining != '0)
                                w_remaining_next = r_remaining - CNT_W'(1);
                            if (r_remaining > CNT_W'(1)) begin
                                w_state_next = S_REQ;
                                w_rdreq_next = !rdempty;
                            end else begin
                                w_state_next  = S_DONE;
                                w_finish_next = 1'b1;
                            end
                        end else begin
                            w_shift_next   = w_shifted;
                            w_tx_data_next = w_shifted[7:0];
                            w_idx_next     = r_idx + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    w_tx_valid_next = 1'b0;
                end
                default: begin
                    w_state_next    = S_IDLE;
                    w_tx_valid_next = 1'b0;
                    w_finish_next   = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge locked) begin
        if (!locked) begin
            r_state     <= S_IDLE;
            r_enout_d   <= 1'b0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_idx       <= 2'd0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_rdreq     <= 1'b0;
            r_finish    <= 1'b0;
            r_underrun  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_enout_d   <= ENOUT;
            r_remaining <= w_remaining_next;
            r_shift     <= w_shift_next;
            r_idx       <= w_idx_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_valid  <= w_tx_valid_next;
            r_rdreq     <= w_rdreq_next;
            r_finish    <= w_finish_next;
            r_underrun  <= w_underrun_next;
            r_busy      <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
        end
    end

    assign rdreq    = r_rdreq;
    assign TxData   = r_tx_data;
    assign TxValid  = r_tx_valid;
    assign FinishRD = r_finish;
    assign Underrun = r_underrun;
    assign Busy     = r_busy;
    assign state    = r_state;

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Scoreboard bench for capture_readout_ctrl: FIFO model feeds words, expected bytes are
// queued at stimulus time and popped on every observed byte handshake.
module tb_capture_readout_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 12;
`ifdef READOUT_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              locked = 1'b0;
    logic              ENOUT = 1'b0;
    logic [CNT_W-1:0]  SampleCount = '0;
    logic              rdempty;
    logic              rdreq;
    logic [DATA_W-1:0] q = '0;
    logic [7:0]        TxData;
    logic              TxValid;
    logic              TxReady = 1'b1;
    logic              FinishRD;
    logic              Underrun;
    logic              Busy;
    logic [2:0]        state;

    capture_readout_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .locked(locked), .ENOUT(ENOUT), .SampleCount(SampleCount),
        .rdempty(rdempty), .rdreq(rdreq), .q(q), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .FinishRD(FinishRD), .Underrun(Underrun), .Busy(Busy),
        .state(state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: one word per rdreq cycle, data valid the following cycle.
    logic [15:0] mem [0:8191];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   rdreq_cnt = 0;
    logic flush = 1'b0;
    assign rdempty = (rd_ptr == wr_ptr);

    always @(posedge CLK) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (rdreq) begin
            q         <= mem[rd_ptr[12:0]];
            rd_ptr    <= rd_ptr + 1;
            rdreq_cnt <= rdreq_cnt + 1;
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    logic [7:0] exp_q[$];
    int   bytes_seen = 0;
    logic stall_d = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic rdreq_d = 1'b0;

    always @(negedge CLK) begin
        if (!locked) begin
            stall_d = 1'b0;
            rdreq_d = 1'b0;
        end else begin
            if (TxValid && stall_d) check("tx_hold", TxData, stall_data);
            stall_d    = TxValid && !TxReady;
            stall_data = TxData;
            if (TxValid && TxReady) begin
                if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
                else check("byte", TxData, exp_q.pop_front());
                bytes_seen++;
            end
            if (rdreq) begin
                check("rdreq_nonempty", rdempty, 1'b0);
                check("rdreq_gap", rdreq_d, 1'b0);
            end
            rdreq_d = rdreq;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [15:0] w);
        mem[wr_ptr[12:0]] = w;
        wr_ptr++;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic push_header(input logic [CNT_W-1:0] n);
        logic [15:0] c;
        c = 16'(n);
        if (HDR_EN) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(c[7:0]);
            exp_q.push_back(c[15:8]);
        end
    endtask

    task automatic start(input logic [CNT_W-1:0] n);
        SampleCount = n;
        push_header(n);
        ENOUT = 1'b1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_finish(input int max_cyc, input bit toggle);
        for (int i = 0; i < max_cyc && !FinishRD; i++) begin
            tick();
            if (toggle) TxReady = ~TxReady;
        end
        TxReady = 1'b1;
        check("finish_seen", FinishRD, 1'b1);
    endtask

    task automatic end_readout(input logic exp_under, input int exp_pulses, input int p0);
        check("stream_len", 32'(exp_q.size()), 32'd0);
        check("underrun", Underrun, exp_under);
        check("rdreq_pulses", 32'(rdreq_cnt - p0), 32'(exp_pulses));
        check("done_state", state, 3'd5);
        check("done_busy", Busy, 1'b0);
        check("done_valid", TxValid, 1'b0);
        ENOUT = 1'b0;
        tick();
        check("finish_clear", FinishRD, 1'b0);
        check("idle_state", state, 3'd0);
        check("underrun_sticky", Underrun, exp_under);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int b0;
        logic act;
        logic [15:0] aw [0:5];

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_rdreq", rdreq, 1'b0);
        check("rst_valid", TxValid, 1'b0);
        check("rst_data", TxData, 8'h00);
        check("rst_finish", FinishRD, 1'b0);
        check("rst_underrun", Underrun, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_state", state, 3'd0);
        tick();
        locked = 1'b1;
        tick();

        // Asynchronous reset while a byte is stalled on the link
        load(16'h5566);
        TxReady = 1'b0;
        SampleCount = 12'd1;
        ENOUT = 1'b1;
        for (int i = 0; i < 20 && !TxValid; i++) tick();
        check("valid_before_reset", TxValid, 1'b1);
        #2 locked = 1'b0;
        #1;
        check("arst_valid", TxValid, 1'b0);
        check("arst_data", TxData, 8'h00);
        check("arst_rdreq", rdreq, 1'b0);
        check("arst_busy", Busy, 1'b0);
        check("arst_state", state, 3'd0);
        ENOUT = 1'b0;
        exp_q.delete();
        do_flush();
        tick();
        locked = 1'b1;
        TxReady = 1'b1;
        p0 = rdreq_cnt;
        act = 1'b0;
        repeat (10) begin
            tick();
            act = act | TxValid | rdreq | Busy | FinishRD;
        end
        check("quiet_after_reset", act, 1'b0);
        check("quiet_rdreq", 32'(rdreq_cnt - p0), 32'd0);

        // Three words, host always ready
        p0 = rdreq_cnt;
        load(16'h1234); load(16'hABCD); load(16'h00FF);
        start(12'd3);
        push_word(16'h1234); push_word(16'hABCD); push_word(16'h00FF);
        wait_finish(100, 1'b0);
        end_readout(1'b0, 3, p0);

        // Same stream with host ready toggling every cycle
        p0 = rdreq_cnt;
        load(16'h1234); load(16'hABCD); load(16'h00FF);
        start(12'd3);
        push_word(16'h1234); push_word(16'hABCD); push_word(16'h00FF);
        wait_finish(200, 1'b1);
        end_readout(1'b0, 3, p0);

        // Underrun: four words requested, two available
        p0 = rdreq_cnt;
        load(16'hBEEF); load(16'h0102);
        start(12'd4);
        push_word(16'hBEEF); push_word(16'h0102);
        wait_finish(100, 1'b0);
        end_readout(1'b1, 2, p0);

        // Abort after the first byte, then restart with the same count
        aw[0] = 16'hC001; aw[1] = 16'hC102; aw[2] = 16'hC203;
        aw[3] = 16'hC304; aw[4] = 16'hC405; aw[5] = 16'hC506;
        for (int i = 0; i < 5; i++) load(aw[i]);
        p0 = rdreq_cnt;
        SampleCount = 12'd5;
        ENOUT = 1'b1;
        exp_q.push_back(HDR_EN ? 8'hA5 : aw[0][7:0]);
        b0 = bytes_seen;
        tick();
        check("underrun_cleared", Underrun, 1'b0);
        for (int i = 0; i < 50 && bytes_seen == b0; i++) tick();
        check("first_byte_seen", 32'(bytes_seen - b0), 32'd1);
        ENOUT = 1'b0;
        TxReady = 1'b0;
        tick();
        check("abort_state", state, 3'd0);
        check("abort_valid", TxValid, 1'b0);
        check("abort_rdreq", rdreq, 1'b0);
        check("abort_busy", Busy, 1'b0);
        check("abort_finish", FinishRD, 1'b0);
        check("abort_pulses", 32'(rdreq_cnt - p0), HDR_EN ? 32'd0 : 32'd1);
        act = 1'b0;
        repeat (4) begin
            tick();
            act = act | FinishRD | TxValid;
        end
        check("abort_quiet", act, 1'b0);
        check("abort_stream", 32'(exp_q.size()), 32'd0);
        TxReady = 1'b1;
        load(aw[5]);
        p0 = rdreq_cnt;
        start(12'd5);
        for (int i = 0; i < 5; i++) push_word(HDR_EN ? aw[i] : aw[i+1]);
        wait_finish(200, 1'b0);
        end_readout(1'b0, 5, p0);
        do_flush();

        // Zero count
        p0 = rdreq_cnt;
        start(12'd0);
        wait_finish(20, 1'b0);
        end_readout(1'b0, 0, p0);

        // Count 0x102 (header bytes A5 02 01 when enabled)
        p0 = rdreq_cnt;
        for (int i = 0; i < 258; i++) load(16'(16'h0100 + i));
        start(12'h102);
        for (int i = 0; i < 258; i++) push_word(16'(16'h0100 + i));
        wait_finish(1500, 1'b0);
        end_readout(1'b0, 258, p0);

        // Maximum count must run to completion
        p0 = rdreq_cnt;
        for (int i = 0; i < 4095; i++) load(16'(i * 7 + 3));
        start(12'hFFF);
        for (int i = 0; i < 4095; i++) push_word(16'(i * 7 + 3));
        wait_finish(20000, 1'b0);
        end_readout(1'b0, 4095, p0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
